// File: rtl/paillier_mont_job_sched.sv
// ---------------------------------------------------------------------------
// paillier_mont_job_sched
//
// Job sequencer that sits directly in front of the Montgomery ME/MM engine.
// A job arrives as N operand beats (one x word and one y word per beat) on a
// valid/ready stream. The sequencer:
//   - issues exactly one me_start or mm_start pulse for the job,
//   - forwards the N operand words, low word first, to the selected engine,
//   - captures the N result words into a local N x K buffer,
//   - returns the results on a valid/ready stream. This supplies the
//     backpressure that the engine itself cannot apply.
// Only one job is in flight at a time, so the engine's ME/MM selection never
// changes in the middle of a job.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   s_valid/s_ready          operand beat handshake
//   s_op                     job op, latched on the first beat
//                            (bit2=1 ME, bit2=0 MM with mm_type=s_op[1:0])
//   s_x, s_y, s_last         operand words; s_last marks beat N-1
//   m_valid/m_ready          result word handshake
//   m_data, m_last           result word (low word first); m_last marks word N-1
//   me_start, me_x*, me_y*   ME engine job start and operand strobes
//   me_result, me_valid      ME engine result strobe
//   mm_type, mm_start,
//   mm_x*, mm_y*             MM engine op type, job start and operand strobes
//   mm_result, mm_valid      MM engine result strobe
//   busy                     high whenever the FSM is not idle
//   err_len                  one-cycle pulse when s_last is misplaced
//   err_to                   one-cycle pulse when the result wait times out
// ---------------------------------------------------------------------------
module paillier_mont_job_sched #(
  parameter int K    = 128,
  parameter int N    = 32,
  parameter int TO_W = 24
) (
  input  logic           clk,
  input  logic           rst,

  input  logic           s_valid,
  output logic           s_ready,
  input  logic [2:0]     s_op,
  input  logic [K-1:0]   s_x,
  input  logic [K-1:0]   s_y,
  input  logic           s_last,

  output logic           m_valid,
  input  logic           m_ready,
  output logic [K-1:0]   m_data,
  output logic           m_last,

  output logic           me_start,
  output logic [K-1:0]   me_x,
  output logic           me_x_valid,
  output logic [K-1:0]   me_y,
  output logic           me_y_valid,
  input  logic [K-1:0]   me_result,
  input  logic           me_valid,

  output logic [1:0]     mm_type,
  output logic           mm_start,
  output logic [K-1:0]   mm_x,
  output logic           mm_x_valid,
  output logic [K-1:0]   mm_y,
  output logic           mm_y_valid,
  input  logic [K-1:0]   mm_result,
  input  logic           mm_valid,

  output logic           busy,
  output logic           err_len,
  output logic           err_to
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LOAD,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q;
  logic [CW-1:0]   bcnt_q;     // operand beat index within the job
  logic [CW-1:0]   wcnt_q;     // result buffer write pointer
  logic [CW-1:0]   rcnt_q;     // result buffer read pointer
  logic [TO_W-1:0] to_cnt_q;   // cycles since the last captured result word

  logic [K-1:0]    fwd_x_q, fwd_y_q;
  logic            fwd_me_q, fwd_mm_q;
  logic            err_len_q, err_to_q;

  logic [K-1:0]    res_buf [N];

  // -------------------------------------------------------------------------
  // Per-cycle decode
  // -------------------------------------------------------------------------
  logic          job_me;
  logic          beat_acc;
  logic          last_beat;
  logic          res_vld;
  logic [K-1:0]  res_data;
  logic          cap;
  logic          to_hit;

  assign job_me    = op_q[2];
  assign beat_acc  = (state_q == S_LOAD) && s_valid;
  assign last_beat = (bcnt_q == LAST_IDX);
  // Strobes from the engine that was not started for this job are ignored.
  assign res_vld   = job_me ? me_valid  : mm_valid;
  assign res_data  = job_me ? me_result : mm_result;
  assign cap       = (state_q == S_WAIT) && res_vld;
  // The timeout fires on the cycle the counter sits at all-ones with no
  // result arriving, i.e. after 2^TO_W quiet cycles.
  assign to_hit    = (state_q == S_WAIT) && !res_vld && (to_cnt_q == '1);

  // -------------------------------------------------------------------------
  // Next-state and state-decoded outputs
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    s_ready  = 1'b0;
    me_start = 1'b0;
    mm_start = 1'b0;
    m_valid  = 1'b0;
    m_last   = 1'b0;
    busy     = (state_q != S_IDLE);
    mm_type  = (state_q != S_IDLE && !job_me) ? op_q[1:0] : 2'b00;

    unique case (state_q)
      S_IDLE: begin
        // The first beat is only peeked at here: its op is latched but the
        // beat itself is consumed later in LOAD.
        if (s_valid) state_d = S_START;
      end
      S_START: begin
        me_start = job_me;
        mm_start = !job_me;
        state_d  = S_LOAD;
      end
      S_LOAD: begin
        s_ready = 1'b1;
        // Beat count alone ends the load; s_last is only checked, never obeyed.
        if (s_valid && last_beat) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cap && wcnt_q == LAST_IDX) state_d = S_DRAIN;
        else if (to_hit)               state_d = S_IDLE;
      end
      S_DRAIN: begin
        m_valid = 1'b1;
        m_last  = (rcnt_q == LAST_IDX);
        if (m_ready && m_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control state, counters and the operand forwarding register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same pre-edge values, independent of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      bcnt_q    <= '0;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      to_cnt_q  <= '0;
      fwd_x_q   <= '0;
      fwd_y_q   <= '0;
      fwd_me_q  <= 1'b0;
      fwd_mm_q  <= 1'b0;
      err_len_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == S_IDLE && s_valid) op_q <= s_op;

      // Accepted beats go out on the selected engine one cycle later, which
      // also keeps the first strobe strictly after the start pulse.
      fwd_me_q <= beat_acc && job_me;
      fwd_mm_q <= beat_acc && !job_me;
      if (beat_acc) begin
        fwd_x_q <= s_x;
        fwd_y_q <= s_y;
      end

      err_len_q <= beat_acc && (s_last != last_beat);
      err_to_q  <= to_hit;

      if (state_q != S_LOAD)  bcnt_q <= '0;
      else if (beat_acc)      bcnt_q <= bcnt_q + 1'b1;

      if (state_q != S_WAIT) begin
        wcnt_q   <= '0;
        to_cnt_q <= '0;
      end else if (cap) begin
        wcnt_q   <= wcnt_q + 1'b1;
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end

      if (state_q != S_DRAIN) rcnt_q <= '0;
      else if (m_ready)       rcnt_q <= rcnt_q + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Result buffer: one write port (engine side), one read port (drain side)
  // -------------------------------------------------------------------------
  // NOTE: the buffer has no reset; a word is always written in WAIT before it
  // can be read in DRAIN, so its power-up contents are never observed.
  always_ff @(posedge clk) begin
    if (cap) res_buf[wcnt_q] <= res_data;
  end

  // Combinational read so m_data is valid in the same cycle as m_valid; it
  // stays stable during a stall because rcnt_q only moves on a handshake.
  assign m_data = (state_q == S_DRAIN) ? res_buf[rcnt_q] : '0;

  assign me_x       = fwd_x_q;
  assign me_y       = fwd_y_q;
  assign me_x_valid = fwd_me_q;
  assign me_y_valid = fwd_me_q;
  assign mm_x       = fwd_x_q;
  assign mm_y       = fwd_y_q;
  assign mm_x_valid = fwd_mm_q;
  assign mm_y_valid = fwd_mm_q;
  assign err_len    = err_len_q;
  assign err_to     = err_to_q;

endmodule

// File: tb/tb_paillier_mont_job_sched.sv
// ---------------------------------------------------------------------------
// Self-checking bench for paillier_mont_job_sched (K=128, N=4, TO_W=4).
// A behavioural engine model answers each job with random result words; the
// bench keeps the expected forwarded operands, result words, start pulses and
// error pulses in queues and counters and compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_paillier_mont_job_sched;

  localparam int K     = 128;
  localparam int N     = 4;
  localparam int TO_W  = 4;
  localparam int BOUND = 60;

  logic           clk = 1'b0;
  logic           rst;
  logic           s_valid, s_ready, s_last;
  logic [2:0]     s_op;
  logic [K-1:0]   s_x, s_y;
  logic           m_valid, m_ready, m_last;
  logic [K-1:0]   m_data;
  logic           me_start, me_x_valid, me_y_valid, me_valid;
  logic [K-1:0]   me_x, me_y, me_result;
  logic [1:0]     mm_type;
  logic           mm_start, mm_x_valid, mm_y_valid, mm_valid;
  logic [K-1:0]   mm_x, mm_y, mm_result;
  logic           busy, err_len, err_to;

  paillier_mont_job_sched #(.K(K), .N(N), .TO_W(TO_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_op       (s_op),
    .s_x        (s_x),
    .s_y        (s_y),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .me_start   (me_start),
    .me_x       (me_x),
    .me_x_valid (me_x_valid),
    .me_y       (me_y),
    .me_y_valid (me_y_valid),
    .me_result  (me_result),
    .me_valid   (me_valid),
    .mm_type    (mm_type),
    .mm_start   (mm_start),
    .mm_x       (mm_x),
    .mm_x_valid (mm_x_valid),
    .mm_y       (mm_y),
    .mm_y_valid (mm_y_valid),
    .mm_result  (mm_result),
    .mm_valid   (mm_valid),
    .busy       (busy),
    .err_len    (err_len),
    .err_to     (err_to)
  );

  always #5 clk = ~clk;

  // Scoreboard state
  int checks = 0;
  int errors = 0;
  int me_start_cnt = 0, mm_start_cnt = 0, job_starts = 0;
  int err_len_cnt = 0, err_to_cnt = 0, mvalid_cnt = 0;
  bit cur_is_me = 1'b1;
  logic [1:0] cur_type = 2'b00;
  bit job_active = 1'b0;
  bit stall_prev = 1'b0;
  logic [K-1:0] prev_data = '0;

  logic [K-1:0] fwd_x_q[$], fwd_y_q[$], exp_q[$], out_q[$];
  bit           out_last_q[$];

  task automatic check(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [K-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Output monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (me_start || mm_start) begin
        check("start_exclusive", {127'd0, me_start & mm_start}, '0);
        if (me_start) me_start_cnt++;
        if (mm_start) mm_start_cnt++;
        job_starts++;
      end
      if (me_x_valid || me_y_valid || mm_x_valid || mm_y_valid) begin
        check("strobe_after_one_start", K'(job_starts), K'(1));
        check("strobe_engine_select", {124'd0, me_x_valid, me_y_valid, mm_x_valid, mm_y_valid},
              cur_is_me ? K'(4'b1100) : K'(4'b0011));
        fwd_x_q.push_back(cur_is_me ? me_x : mm_x);
        fwd_y_q.push_back(cur_is_me ? me_y : mm_y);
      end
      if (err_len) err_len_cnt++;
      if (err_to)  err_to_cnt++;
      if (m_valid) begin
        mvalid_cnt++;
        if (stall_prev) check("m_data_hold", m_data, prev_data);
        if (m_ready) begin
          out_q.push_back(m_data);
          out_last_q.push_back(m_last);
        end
      end
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      if (job_active && busy && !cur_is_me)
        check("mm_type_held", {126'd0, mm_type}, {126'd0, cur_type});
    end
  end

  // Present one beat and hold it until the sequencer takes it.
  task automatic send_beat(input logic [K-1:0] x, input logic [K-1:0] y, input bit last);
    int n = 0;
    bit acc = 1'b0;
    s_valid = 1'b1;
    s_x     = x;
    s_y     = y;
    s_last  = last;
    while (!acc && n < BOUND) begin
      acc = s_ready;
      step();
      n++;
    end
    check("beat_accepted", {127'd0, acc}, K'(1));
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Engine model: once all N operands have arrived, return nwords results
  // with random gaps, optionally injecting a strobe on the unused engine.
  task automatic engine_respond(input bit is_me, input int nwords, input bit stray);
    int n = 0;
    logic [K-1:0] r;
    while (fwd_x_q.size() < N && n < BOUND) begin
      step();
      n++;
    end
    check("operands_forwarded", K'(fwd_x_q.size()), K'(N));
    for (int i = 0; i < nwords; i++) begin
      repeat ($urandom_range(0, 3)) step();
      if (stray && i == 1) begin
        if (is_me) begin mm_valid = 1'b1; mm_result = rand_word(); end
        else       begin me_valid = 1'b1; me_result = rand_word(); end
        step();
        me_valid = 1'b0;
        mm_valid = 1'b0;
      end
      r = rand_word();
      exp_q.push_back(r);
      if (is_me) begin me_valid = 1'b1; me_result = r; end
      else       begin mm_valid = 1'b1; mm_result = r; end
      step();
      me_valid = 1'b0;
      mm_valid = 1'b0;
    end
  endtask

  // One complete job. ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  task automatic run_job(input logic [2:0] op, input bit directed, input bit gapped,
                         input int bad_beat, input int ready_mode, input int nresp,
                         input bit stray);
    logic [K-1:0] xs[N];
    logic [K-1:0] ys[N];
    bit sl[N];
    int exp_err = 0;
    int me0, mm0, el0, et0, mv0, n, k;
    fwd_x_q.delete(); fwd_y_q.delete(); exp_q.delete();
    out_q.delete(); out_last_q.delete();
    me0 = me_start_cnt; mm0 = mm_start_cnt;
    el0 = err_len_cnt;  et0 = err_to_cnt;  mv0 = mvalid_cnt;
    cur_is_me  = op[2];
    cur_type   = op[1:0];
    job_starts = 0;
    job_active = 1'b1;

    for (int b = 0; b < N; b++) begin
      xs[b] = directed ? K'(b + 1) : rand_word();
      ys[b] = directed ? K'(b + 5) : rand_word();
      sl[b] = (b == N - 1) || (b == bad_beat);
      if (sl[b] != (b == N - 1)) exp_err++;
    end

    s_op = op;
    for (int b = 0; b < N; b++) begin
      if (gapped && b > 0) step();
      send_beat(xs[b], ys[b], sl[b]);
    end
    s_op = 3'b000;
    check("s_ready_low_after_load", {127'd0, s_ready}, '0);
    check("busy_in_wait", {127'd0, busy}, K'(1));

    engine_respond(op[2], nresp, stray);

    if (nresp == N) begin
      n = 0;
      k = 0;
      while (out_q.size() < N && n < BOUND) begin
        case (ready_mode)
          0:       m_ready = 1'b1;
          1:       m_ready = (k % 4 == 0) || (k % 4 == 3);
          default: m_ready = 1'($urandom_range(0, 1));
        endcase
        k++;
        step();
        n++;
      end
      m_ready = 1'b0;
      check("m_valid_low_after_drain", {127'd0, m_valid}, '0);
      check("busy_low_after_drain", {127'd0, busy}, '0);
      check("handshake_count", K'(out_q.size()), K'(N));
      for (int i = 0; i < N && i < out_q.size(); i++) begin
        check("result_word", out_q[i], exp_q[i]);
        check("m_last_flag", {127'd0, out_last_q[i]}, {127'd0, i == N - 1});
      end
    end else begin
      n = 0;
      while (err_to_cnt == et0 && n < BOUND) begin
        step();
        n++;
      end
      check("err_to_pulses", K'(err_to_cnt - et0), K'(1));
      check("busy_low_after_timeout", {127'd0, busy}, '0);
      check("no_m_valid_on_timeout", K'(mvalid_cnt - mv0), '0);
    end

    check("me_start_pulses", K'(me_start_cnt - me0), op[2] ? K'(1) : '0);
    check("mm_start_pulses", K'(mm_start_cnt - mm0), op[2] ? '0 : K'(1));
    check("fwd_total", K'(fwd_x_q.size()), K'(N));
    for (int i = 0; i < N && i < fwd_x_q.size(); i++) begin
      check("fwd_x_word", fwd_x_q[i], xs[i]);
      check("fwd_y_word", fwd_y_q[i], ys[i]);
    end
    check("err_len_pulses", K'(err_len_cnt - el0), K'(exp_err));
    job_active = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int me0, n;
    rst = 1'b1;
    s_valid = 1'b0; s_op = 3'b000; s_x = '0; s_y = '0; s_last = 1'b0;
    m_ready = 1'b0;
    me_valid = 1'b0; me_result = '0;
    mm_valid = 1'b0; mm_result = '0;
    repeat (3) step();

    // Reset state
    check("rst_s_ready",    {127'd0, s_ready},    '0);
    check("rst_m_valid",    {127'd0, m_valid},    '0);
    check("rst_busy",       {127'd0, busy},       '0);
    check("rst_me_start",   {127'd0, me_start},   '0);
    check("rst_mm_start",   {127'd0, mm_start},   '0);
    check("rst_me_x_valid", {127'd0, me_x_valid}, '0);
    check("rst_mm_x_valid", {127'd0, mm_x_valid}, '0);
    check("rst_err_len",    {127'd0, err_len},    '0);
    check("rst_err_to",     {127'd0, err_to},     '0);
    check("rst_mm_type",    {126'd0, mm_type},    '0);
    check("rst_m_data",     m_data,               '0);
    check("rst_me_x",       me_x,                 '0);
    rst = 1'b0;
    step();

    // ME job with x=1..4, y=5..8
    run_job(3'b100, 1'b1, 1'b0, -1, 0, N, 1'b0);
    // MM job, mm_type=2'b10
    run_job(3'b010, 1'b0, 1'b0, -1, 0, N, 1'b0);
    // Drain backpressure 1,0,0,1,...
    run_job(3'b001, 1'b0, 1'b0, -1, 1, N, 1'b0);
    // Gapped operand stream with s_last also asserted on beat 1
    run_job(3'b100, 1'b0, 1'b1, 1, 0, N, 1'b0);
    // Timeout: too few results plus a stray MM strobe during an ME job
    run_job(3'b100, 1'b0, 1'b0, -1, 0, N - 1, 1'b1);
    // Clean job right after the timeout, with a stray strobe that must be ignored
    run_job(3'b100, 1'b0, 1'b0, -1, 2, N, 1'b1);

    // Reset in the middle of LOAD, while beat 2 is on the bus
    fwd_x_q.delete(); fwd_y_q.delete();
    cur_is_me  = 1'b1;
    job_starts = 0;
    job_active = 1'b1;
    s_op = 3'b100;
    send_beat(rand_word(), rand_word(), 1'b0);
    send_beat(rand_word(), rand_word(), 1'b0);
    s_valid = 1'b1;
    s_x = rand_word();
    s_y = rand_word();
    rst = 1'b1;
    step();
    rst = 1'b0;
    s_valid = 1'b0;
    s_op = 3'b000;
    job_active = 1'b0;
    check("midrst_busy",       {127'd0, busy},       '0);
    check("midrst_s_ready",    {127'd0, s_ready},    '0);
    check("midrst_me_x_valid", {127'd0, me_x_valid}, '0);
    check("midrst_me_start",   {127'd0, me_start},   '0);
    check("midrst_m_valid",    {127'd0, m_valid},    '0);
    check("midrst_err_len",    {127'd0, err_len},    '0);
    check("midrst_me_x",       me_x,                 '0);
    fwd_x_q.delete(); fwd_y_q.delete();
    me0 = me_start_cnt;
    repeat (4) step();
    check("midrst_no_strobes", K'(fwd_x_q.size()), '0);
    check("midrst_no_start",   K'(me_start_cnt - me0), '0);

    // Fresh job after the reset starts from beat 0
    run_job(3'b100, 1'b0, 1'b0, -1, 0, N, 1'b0);

    // Randomized jobs
    for (int j = 0; j < 6; j++) begin
      n = int'($urandom_range(0, N));
      run_job(3'($urandom_range(0, 7)), 1'b0, 1'($urandom_range(0, 1)),
              (n == N) ? -1 : n, 2, N, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
